mul_product_accumulator: RTL and testbench
==========================================

# mul_product_accumulator

Downstream consumer of the 2-stage registered unsigned multiplier (18×18 → 18-bit product `p`, latency 2, no handshake). Tracks which multiplier outputs are meaningful by delaying the operand-side valid/last flags by the multiplier latency. Accumulates each frame of products into a wide saturating sum. Presents the frame result through a single-entry valid/ready output register.

## Interface
- `WIDTH`, 18: product width; must equal the multiplier output width.
- `LATENCY`, 2: multiplier pipeline depth; sets the valid/last delay line length (≥1).
- `ACC_WIDTH`, 40: accumulator and result width (> `WIDTH`).
- `CNT_WIDTH`, 16: product-count width.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  high in the cycle operands `a`,`b` are presented to the multiplier.
- `in_last`  in  1  qualifies `in_valid`: this operand pair ends the frame.
- `p`  in  `WIDTH`  multiplier product; meaningful `LATENCY` cycles after its `in_valid`.
- `out_valid`  out  1  result register holds an unaccepted frame result.
- `out_ready`  in  1  consumer accepts the result when `out_valid && out_ready`.
- `out_sum`  out  `ACC_WIDTH`  frame sum of products.
- `out_count`  out  `CNT_WIDTH`  number of products in the frame (saturating).
- `out_sat`  out  1  frame sum clamped at all-ones.
- `drop_err`  out  1  sticky: a completed frame was discarded because the result register was occupied.

## Operation
- Delay line: `LATENCY`-deep shift register of {valid, last}; tap `pv`/`pl` aligns with `p`. Cleared on reset.
- Accumulator state `acc`, `cnt`, `sat`, plus a `first` flag (1 = next product starts a frame).
- On `pv`:
  - Base = 0 if `first`, else `acc`. New sum = base + zero-extended `p`. If the carry exceeds `ACC_WIDTH`, the sum becomes all-ones and `sat` is set. `sat` is cleared at frame start.
  - `cnt` = 1 if `first`, else `cnt`+1, saturating at all-ones.
  - If `pl`: the completed {sum, cnt, sat} is the frame result and `first` is set to 1. Otherwise `first` is cleared.
- Result register: loads the frame result when a frame completes and the register is free. Free means `!out_valid` or `out_valid && out_ready` in the same cycle.
  - A completion while the register is occupied and not being accepted discards the new result and sets `drop_err`.
  - The accumulator restarts regardless.
- `drop_err` clears only on reset.
- Single-product frame (`in_valid && in_last`) is legal; result = that product, count 1.
- Products with `pv` = 0 are ignored; `acc` holds.
- Back-to-back frames with no gap are legal.
- Unsigned arithmetic only.

## Timing
- Reset (`rst_n` = 0 at an edge): `out_valid` = 0, `out_sum` = 0, `out_count` = 0, `out_sat` = 0, `drop_err` = 0, `acc` = 0, `cnt` = 0, `first` = 1, delay line = 0.
- Reset mid-frame discards the partial frame and any pending result. Products of operands issued before reset never count, even though they emerge up to `LATENCY` cycles after reset.
- Latency: operands with `in_last` in cycle t → `p` meaningful in cycle t+`LATENCY` → `out_valid` high in cycle t+`LATENCY`+1 with the result.
- `out_valid` stays high and `out_sum`/`out_count`/`out_sat` stay stable until the handshake cycle.
- After a handshake, `out_valid` drops the next cycle unless a completion reloads it in the same edge.
- The `in_valid`/`in_last` path is a pure register chain. The critical path is the `ACC_WIDTH` adder plus saturation mux.

## Test plan
- Frame of products 3, 5, 7 (`a`=3/`b`=1, `a`=5/`b`=1, `a`=7/`b`=1; last on third) with `out_ready`=1 -> `out_valid` for one cycle, 3 cycles after the third `in_valid`; `out_sum`=15, `out_count`=3, `out_sat`=0.
- Two back-to-back frames {2×2} and {4×4, 1×1}, `out_ready`=1 -> results 4 (count 1), then 17 (count 2) on consecutive completions; no `drop_err`.
- `ACC_WIDTH`=20 override; frame of five 2^18−1 products -> `out_sum`=2^20−1, `out_sat`=1. Next frame {1×1} -> `out_sum`=1, `out_sat`=0.
- `out_ready`=0 while frames {1×1} then {2×1} complete -> `out_sum` stays 1, `drop_err`=1. Raise `out_ready` -> one handshake; `out_valid` falls.
- Completion in the same cycle as a handshake of the prior result -> new result loaded with no bubble, `drop_err`=0.
- Assert `rst_n`=0 for one cycle mid-frame, after 2 of 4 operands issued -> all outputs 0. The 2 in-flight products are ignored. A fresh frame {6×7} yields `out_sum`=42, count 1.

Source files
------------

// File: rtl/mul_product_accumulator_if.sv
// Bundles the product stream coming from the multiplier side with the
// valid/ready frame-result stream going to the consumer.
//   in_valid, in_last : operand-side flags, valid in the cycle a/b enter the multiplier
//   p                 : multiplier product, meaningful LATENCY cycles after in_valid
//   out_valid/ready   : single-entry result handshake
//   out_sum/count/sat : frame result
//   drop_err          : sticky flag, a completed frame result was discarded
interface mul_product_accumulator_if #(
  parameter int WIDTH     = 18,
  parameter int ACC_WIDTH = 40,
  parameter int CNT_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_last;
  logic [WIDTH-1:0]     p;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic [CNT_WIDTH-1:0] out_count;
  logic                 out_sat;
  logic                 drop_err;

  // master: the side that feeds products and consumes results
  modport master (
    output in_valid, in_last, p, out_ready,
    input  out_valid, out_sum, out_count, out_sat, drop_err
  );

  // slave: the accumulator itself
  modport slave (
    input  in_valid, in_last, p, out_ready,
    output out_valid, out_sum, out_count, out_sat, drop_err
  );
endinterface

// File: rtl/mul_product_accumulator.sv
// Accumulates frames of products from a LATENCY-stage multiplier into a
// saturating ACC_WIDTH-bit sum and presents each frame result through a
// single-entry valid/ready register.
//   clk   : sole clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of mul_product_accumulator_if (product in, result out)
module mul_product_accumulator #(
  parameter int WIDTH     = 18,
  parameter int LATENCY   = 2,
  parameter int ACC_WIDTH = 40,
  parameter int CNT_WIDTH = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  mul_product_accumulator_if.slave bus
);

  // Operand-side flags delayed to line up with p.
  logic [LATENCY-1:0] vld_sr;
  logic [LATENCY-1:0] lst_sr;
  logic               pv;
  logic               pl;

  assign pv = vld_sr[LATENCY-1];
  assign pl = lst_sr[LATENCY-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_sr <= '0;
      lst_sr <= '0;
    end else begin
      vld_sr[0] <= bus.in_valid;
      lst_sr[0] <= bus.in_valid & bus.in_last;
      for (int i = 1; i < LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        lst_sr[i] <= lst_sr[i-1];
      end
    end
  end

  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 sat;
  logic                 first;

  logic [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH:0]   sum_wide;
  logic [ACC_WIDTH-1:0] sum_nxt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 sat_nxt;

  always_comb begin
    base     = first ? '0 : acc;
    sum_wide = {1'b0, base} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, bus.p};
    // Once clamped, the sum stays all-ones: any further non-zero add carries out again.
    sum_nxt  = sum_wide[ACC_WIDTH] ? '1 : sum_wide[ACC_WIDTH-1:0];
    sat_nxt  = (first ? 1'b0 : sat) | sum_wide[ACC_WIDTH];
    if (first)     cnt_nxt = CNT_WIDTH'(1);
    else if (&cnt) cnt_nxt = cnt;
    else           cnt_nxt = cnt + 1'b1;
  end

  logic                 res_valid;
  logic [ACC_WIDTH-1:0] res_sum;
  logic [CNT_WIDTH-1:0] res_count;
  logic                 res_sat;
  logic                 drop;
  logic                 done;
  logic                 reg_free;
  logic                 accept;

  assign done     = pv & pl;
  assign accept   = res_valid & bus.out_ready;
  assign reg_free = ~res_valid | accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      first     <= 1'b1;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_count <= '0;
      res_sat   <= 1'b0;
      drop      <= 1'b0;
    end else begin
      if (pv) begin
        acc   <= sum_nxt;
        cnt   <= cnt_nxt;
        sat   <= sat_nxt;
        first <= pl;
      end
      if (done && reg_free) begin
        res_valid <= 1'b1;
        res_sum   <= sum_nxt;
        res_count <= cnt_nxt;
        res_sat   <= sat_nxt;
      end else if (accept) begin
        res_valid <= 1'b0;
      end
      // The accumulator restarts either way; only the result is lost.
      if (done && !reg_free) drop <= 1'b1;
    end
  end

  assign bus.out_valid = res_valid;
  assign bus.out_sum   = res_sum;
  assign bus.out_count = res_count;
  assign bus.out_sat   = res_sat;
  assign bus.drop_err  = drop;

endmodule

// File: tb/tb_mul_product_accumulator.sv
// Bench for mul_product_accumulator: two instances (ACC_WIDTH 40 and 20) share
// one product stream from a behavioural 2-stage multiplier. A frame-level
// reference model pushes expected results into per-instance queues; monitors
// pop and compare on every output handshake.
module tb_mul_product_accumulator;
  localparam int W  = 18;
  localparam int L  = 2;
  localparam int CW = 16;
  localparam longint unsigned MAX40 = (64'd1 << 40) - 1;
  localparam longint unsigned MAX20 = (64'd1 << 20) - 1;
  localparam longint unsigned MAXC  = (64'd1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         in_last  = 1'b0;
  logic         rdy      = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] m1 = '0;
  logic [W-1:0] m2 = '0;
  logic [2*W-1:0] prod_full;

  assign prod_full = a * b;

  always @(posedge clk) begin
    m1 <= prod_full[W-1:0];
    m2 <= m1;
  end

  mul_product_accumulator_if #(.WIDTH(W), .ACC_WIDTH(40), .CNT_WIDTH(CW)) bus40 ();
  mul_product_accumulator_if #(.WIDTH(W), .ACC_WIDTH(20), .CNT_WIDTH(CW)) bus20 ();

  assign bus40.in_valid  = in_valid;
  assign bus40.in_last   = in_last;
  assign bus40.p         = m2;
  assign bus40.out_ready = rdy;
  assign bus20.in_valid  = in_valid;
  assign bus20.in_last   = in_last;
  assign bus20.p         = m2;
  assign bus20.out_ready = rdy;

  mul_product_accumulator #(.WIDTH(W), .LATENCY(L), .ACC_WIDTH(40), .CNT_WIDTH(CW)) dut40 (
    .clk(clk), .rst_n(rst_n), .bus(bus40.slave));
  mul_product_accumulator #(.WIDTH(W), .LATENCY(L), .ACC_WIDTH(20), .CNT_WIDTH(CW)) dut20 (
    .clk(clk), .rst_n(rst_n), .bus(bus20.slave));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { longint unsigned prod; bit last; int due; } op_t;
  typedef struct { longint unsigned sum; longint unsigned cnt; } res_t;

  op_t  ops[$];
  res_t q40[$];
  res_t q20[$];
  int   cyc = 0;
  bit   m_first = 1'b1;
  longint unsigned m_sum = 0;
  longint unsigned m_cnt = 0;
  bit   exp_occ = 1'b0;
  bit   exp_drop = 1'b0;

  always @(negedge clk) begin
    op_t  o;
    res_t r;
    bit   done;
    bit   accepted;
    cyc++;
    if (!rst_n) begin
      ops.delete();
      q40.delete();
      q20.delete();
      m_first  = 1'b1;
      m_sum    = 0;
      m_cnt    = 0;
      exp_occ  = 1'b0;
      exp_drop = 1'b0;
    end else begin
      check("out_valid40", bus40.out_valid, exp_occ);
      check("out_valid20", bus20.out_valid, exp_occ);
      check("drop_err40", bus40.drop_err, exp_drop);
      check("drop_err20", bus20.drop_err, exp_drop);
      accepted = exp_occ && rdy;
      done = 1'b0;
      r = '{0, 0};
      if (in_valid) ops.push_back('{longint'(prod_full[W-1:0]), in_last, cyc + L});
      while (ops.size() > 0 && ops[0].due == cyc) begin
        o = ops.pop_front();
        if (m_first) begin m_sum = 0; m_cnt = 0; end
        m_sum += o.prod;
        m_cnt++;
        m_first = 1'b0;
        if (o.last) begin
          done = 1'b1;
          r = '{m_sum, m_cnt};
          m_first = 1'b1;
        end
      end
      if (done) begin
        if (!exp_occ || accepted) begin
          q40.push_back(r);
          q20.push_back(r);
          exp_occ = 1'b1;
        end else begin
          exp_drop = 1'b1;
        end
      end else if (accepted) begin
        exp_occ = 1'b0;
      end
    end
  end

  // ---------------- monitors ----------------
  task automatic compare_result(input string tag, input res_t r, input longint unsigned maxv,
                                input logic [63:0] sum, input logic [63:0] cnt, input logic sat);
    longint unsigned es, ec;
    es = (r.sum > maxv) ? maxv : r.sum;
    ec = (r.cnt > MAXC) ? MAXC : r.cnt;
    check({tag, "_sum"}, sum, es);
    check({tag, "_count"}, cnt, ec);
    check({tag, "_sat"}, 64'(sat), 64'(r.sum > maxv));
  endtask

  always @(negedge clk) begin
    res_t r;
    if (rst_n && bus40.out_valid && rdy) begin
      if (q40.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb40: handshake got result %0d expected no result", bus40.out_sum);
      end else begin
        r = q40.pop_front();
        compare_result("res40", r, MAX40, 64'(bus40.out_sum), 64'(bus40.out_count), bus40.out_sat);
      end
    end
  end

  always @(negedge clk) begin
    res_t r;
    if (rst_n && bus20.out_valid && rdy) begin
      if (q20.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb20: handshake got result %0d expected no result", bus20.out_sum);
      end else begin
        r = q20.pop_front();
        compare_result("res20", r, MAX20, 64'(bus20.out_sum), 64'(bus20.out_count), bus20.out_sat);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input int av, input int bv, input bit last);
    in_valid = 1'b1;
    a = W'(av);
    b = W'(bv);
    in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid40"}, bus40.out_valid, 0);
    check({tag, "_sum40"}, 64'(bus40.out_sum), 0);
    check({tag, "_count40"}, 64'(bus40.out_count), 0);
    check({tag, "_sat40"}, bus40.out_sat, 0);
    check({tag, "_drop40"}, bus40.drop_err, 0);
    check({tag, "_valid20"}, bus20.out_valid, 0);
    check({tag, "_sum20"}, 64'(bus20.out_sum), 0);
    check({tag, "_drop20"}, bus20.drop_err, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    rdy = 1'b1;
    idle(3);
    rst_n = 1'b1;
    check_cleared("reset");

    // frame 3+5+7
    issue(3, 1, 0); issue(5, 1, 0); issue(7, 1, 1);
    idle(6);

    // back-to-back frames {2x2}, {4x4, 1x1}
    issue(2, 2, 1); issue(4, 4, 0); issue(1, 1, 1);
    idle(6);

    // five full-scale products: clamps in the 20-bit instance, then a fresh frame
    for (int i = 0; i < 5; i++) issue((1 << W) - 1, 1, i == 4);
    issue(1, 1, 1);
    idle(6);

    // completion in the same cycle as the handshake of the prior result
    rdy = 1'b0;
    issue(3, 3, 1);
    idle(4);
    issue(4, 4, 1);
    idle(1);
    rdy = 1'b1;
    idle(1);
    rdy = 1'b0;
    check("nobubble_valid", bus40.out_valid, 1);
    check("nobubble_sum", 64'(bus40.out_sum), 16);
    check("nobubble_drop", bus40.drop_err, 0);
    idle(2);
    rdy = 1'b1;
    idle(3);

    // result held while out_ready is low; second completion is dropped
    rdy = 1'b0;
    issue(1, 1, 1);
    idle(2);
    issue(2, 1, 1);
    idle(5);
    check("hold_sum", 64'(bus40.out_sum), 1);
    check("hold_drop", bus40.drop_err, 1);
    rdy = 1'b1;
    idle(1);
    rdy = 1'b0;
    idle(2);
    check("after_hs_valid", bus40.out_valid, 0);
    rdy = 1'b1;

    // reset mid-frame after two of four operands
    issue(9, 9, 0); issue(8, 8, 0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check_cleared("midreset");
    issue(6, 7, 1);
    idle(4);
    check("fresh_sum", 64'(bus40.out_sum), 42);
    check("fresh_count", 64'(bus40.out_count), 1);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_last  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) begin
        a = W'($urandom);
        b = W'($urandom);
      end else begin
        a = W'($urandom_range(0, 255));
        b = W'($urandom_range(0, 255));
      end
      rdy = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    rdy = 1'b1;
    idle(10);
    check("drain40", q40.size(), 0);
    check("drain20", q20.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
